// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART motion-command sequencer.
// Pure declarations, no latency.
// No flow control; consumers act on i_done strobes only.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int CMD_RIGHT = 0;
    localparam int CMD_LEFT  = 1;
    localparam int CMD_UP    = 2;
    localparam int CMD_DOWN  = 3;
    localparam int CMD_TRIG  = 4;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        CMD  = 2'd1,
        DUR  = 2'd2,
        CHK  = 2'd3
    } parse_state_t;

    typedef logic [4:0] cmd_pat_t;

    // A STOP frame (DUR=0) may carry any legal pattern; only CMD=0 with a hold time is rejected.
    function automatic logic frame_valid(input logic [7:0] cmd, input logic [7:0] dur,
                                         input logic [7:0] chk);
        return ((cmd ^ dur) == chk)
            && (cmd[7:5] == 3'b000)
            && !(cmd[CMD_RIGHT] && cmd[CMD_LEFT])
            && !(cmd[CMD_UP] && cmd[CMD_DOWN])
            && !((cmd == 8'h00) && (dur != 8'h00));
    endfunction

endpackage

// File: rtl/cmd_ms_tick.sv
// Millisecond tick generator: pulses o_tick once every CLKS_PER_MS cycles after i_clear.
// Tick is combinational from the counter and lands on the last cycle of each ms.
// No backpressure; i_clear restarts the period.
module cmd_ms_tick #(
    parameter int CLKS_PER_MS = 25000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames UART bytes into A5/CMD/DUR/CHK motion commands and drives timed outputs.
// Outputs and status pulses appear one cycle after the CHK byte strobe.
// No backpressure: one active run plus a one-deep pending slot, latest frame wins.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_MS      = 25000,
    parameter int FRAME_TIMEOUT_MS = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_done,
    input  logic [7:0] i_data,
    output logic       o_right,
    output logic       o_left,
    output logic       o_up,
    output logic       o_down,
    output logic       o_trigger,
    output logic       o_busy,
    output logic       o_frame_ok,
    output logic       o_err,
    output logic       o_ovr
);

    localparam int TW = (FRAME_TIMEOUT_MS > 1) ? $clog2(FRAME_TIMEOUT_MS + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(FRAME_TIMEOUT_MS - 1);

    parse_state_t state_q, state_d;
    logic [7:0]   cmd_q, dur_q;
    logic [TW-1:0] to_ms_q;
    logic         to_tick, to_clear, to_fire;
    logic         frame_chk, frame_good, go_stop, go_run;

    cmd_pat_t     act_q, act_d, pend_pat_q, pend_pat_d, new_pat;
    logic [7:0]   rem_q, rem_d, pend_dur_q, pend_dur_d;
    logic         busy_q, busy_d, pend_vld_q, pend_vld_d;
    logic         run_tick, run_end, run_clear, load, ovr_d;
    logic         frame_ok_q, err_q, ovr_q;

    // Frame watchdog: counts whole ms between bytes; idle in SYNC.
    assign to_clear = i_done || (state_q == SYNC);
    assign to_fire  = (state_q != SYNC) && !i_done && to_tick && (to_ms_q == TO_LAST);

    cmd_ms_tick #(.CLKS_PER_MS(CLKS_PER_MS)) u_to_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (to_clear),
        .o_tick  (to_tick)
    );

    always_comb begin
        state_d   = state_q;
        frame_chk = 1'b0;
        if (to_fire) begin
            state_d = SYNC;
        end else if (i_done) begin
            case (state_q)
                SYNC:    if (i_data == SYNC_BYTE) state_d = CMD;
                CMD:     state_d = DUR;
                DUR:     state_d = CHK;
                CHK: begin
                    state_d   = SYNC;
                    frame_chk = 1'b1;
                end
                default: state_d = SYNC;
            endcase
        end
    end

    assign frame_good = frame_chk && frame_valid(cmd_q, dur_q, i_data);
    assign go_stop    = frame_good && (dur_q == 8'd0);
    assign go_run     = frame_good && (dur_q != 8'd0);
    assign new_pat    = cmd_q[4:0];

    cmd_ms_tick #(.CLKS_PER_MS(CLKS_PER_MS)) u_run_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (run_clear),
        .o_tick  (run_tick)
    );

    assign run_end   = busy_q && run_tick && (rem_q == 8'd1);
    assign run_clear = load || !busy_q;

    always_comb begin
        act_d      = act_q;
        busy_d     = busy_q;
        rem_d      = rem_q;
        pend_vld_d = pend_vld_q;
        pend_pat_d = pend_pat_q;
        pend_dur_d = pend_dur_q;
        ovr_d      = 1'b0;
        load       = 1'b0;
        if (go_stop) begin
            act_d      = '0;
            busy_d     = 1'b0;
            rem_d      = 8'd0;
            pend_vld_d = 1'b0;
        end else if (run_end) begin
            // Hand-over at run end never counts as an overwrite.
            if (pend_vld_q) begin
                act_d      = pend_pat_q;
                rem_d      = pend_dur_q;
                load       = 1'b1;
                pend_vld_d = go_run;
                pend_pat_d = new_pat;
                pend_dur_d = dur_q;
            end else if (go_run) begin
                act_d = new_pat;
                rem_d = dur_q;
                load  = 1'b1;
            end else begin
                act_d  = '0;
                busy_d = 1'b0;
                rem_d  = 8'd0;
            end
        end else begin
            if (busy_q && run_tick) rem_d = rem_q - 8'd1;
            if (go_run) begin
                if (!busy_q) begin
                    act_d  = new_pat;
                    busy_d = 1'b1;
                    rem_d  = dur_q;
                    load   = 1'b1;
                end else begin
                    ovr_d      = pend_vld_q;
                    pend_vld_d = 1'b1;
                    pend_pat_d = new_pat;
                    pend_dur_d = dur_q;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= SYNC;
            cmd_q      <= 8'd0;
            dur_q      <= 8'd0;
            to_ms_q    <= '0;
            act_q      <= '0;
            busy_q     <= 1'b0;
            rem_q      <= 8'd0;
            pend_vld_q <= 1'b0;
            pend_pat_q <= '0;
            pend_dur_q <= 8'd0;
            frame_ok_q <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (i_done && (state_q == CMD)) cmd_q <= i_data;
            if (i_done && (state_q == DUR)) dur_q <= i_data;
            if (to_clear)     to_ms_q <= '0;
            else if (to_tick) to_ms_q <= to_ms_q + 1'b1;
            act_q      <= act_d;
            busy_q     <= busy_d;
            rem_q      <= rem_d;
            pend_vld_q <= pend_vld_d;
            pend_pat_q <= pend_pat_d;
            pend_dur_q <= pend_dur_d;
            frame_ok_q <= frame_good;
            err_q      <= (frame_chk && !frame_good) || to_fire;
            ovr_q      <= ovr_d;
        end
    end

    assign o_right    = act_q[CMD_RIGHT];
    assign o_left     = act_q[CMD_LEFT];
    assign o_up       = act_q[CMD_UP];
    assign o_down     = act_q[CMD_DOWN];
    assign o_trigger  = act_q[CMD_TRIG];
    assign o_busy     = busy_q;
    assign o_frame_ok = frame_ok_q;
    assign o_err      = err_q;
    assign o_ovr      = ovr_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: directed scenarios plus random byte streams,
// checked every cycle against a frame/absolute-deadline reference model.
module tb_uart_cmd_sequencer;

    localparam int CLKS    = 10;
    localparam int TMO_MS  = 2;
    localparam int TMO_CYC = CLKS * TMO_MS;

    logic       i_clk, i_rst_n, i_done;
    logic [7:0] i_data;
    logic       o_right, o_left, o_up, o_down, o_trigger;
    logic       o_busy, o_frame_ok, o_err, o_ovr;

    uart_cmd_sequencer #(.CLKS_PER_MS(CLKS), .FRAME_TIMEOUT_MS(TMO_MS)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_done     (i_done),
        .i_data     (i_data),
        .o_right    (o_right),
        .o_left     (o_left),
        .o_up       (o_up),
        .o_down     (o_down),
        .o_trigger  (o_trigger),
        .o_busy     (o_busy),
        .o_frame_ok (o_frame_ok),
        .o_err      (o_err),
        .o_ovr      (o_ovr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // bit order: 0 right,1 left,2 up,3 down,4 trig,5 ovr,6 err,7 ok,8 busy
    logic [8:0] dut_vec;
    assign dut_vec = {o_busy, o_frame_ok, o_err, o_ovr, o_trigger, o_down, o_up, o_left, o_right};

    int n_checks = 0;
    int n_fail   = 0;
    int pcount   = 0;
    bit chk_en   = 1'b0;
    int hi[9];
    int snap[9];
    int err_at   = -1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, pcount, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] fb[$];
    int         last_byte_p;
    logic [7:0] mc, md, mk;
    bit         m_motion, m_stop, ending;
    bit         a_vld, p_vld;
    logic [4:0] a_pat, p_pat;
    int         a_end, p_dur, p;
    logic [4:0] e_pat;
    bit         e_busy, e_ok, e_err, e_ovr;

    function automatic bit legal(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        int bad;
        bad = 0;
        if ((c ^ d) != k)              bad++;
        if (c > 8'h1F)                 bad++;
        if (c[0] && c[1])              bad++;
        if (c[2] && c[3])              bad++;
        if (c == 8'h00 && d != 8'h00)  bad++;
        return bad == 0;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fb.delete();
            a_vld = 0; p_vld = 0;
            e_pat = '0; e_busy = 0; e_ok = 0; e_err = 0; e_ovr = 0;
        end else begin
            p = pcount + 1;
            pcount = p;
            e_ok = 0; e_err = 0; e_ovr = 0; m_motion = 0; m_stop = 0;
            mc = 8'h00; md = 8'h00;
            if (i_done) begin
                last_byte_p = p;
                if (fb.size() == 0) begin
                    if (i_data == 8'hA5) fb.push_back(i_data);
                end else begin
                    fb.push_back(i_data);
                    if (fb.size() == 4) begin
                        mc = fb[1]; md = fb[2]; mk = fb[3];
                        fb.delete();
                        if (legal(mc, md, mk)) begin
                            e_ok = 1;
                            if (md == 8'h00) m_stop = 1; else m_motion = 1;
                        end else begin
                            e_err = 1;
                        end
                    end
                end
            end else if (fb.size() != 0 && (p - last_byte_p) == TMO_CYC) begin
                e_err = 1;
                fb.delete();
            end
            ending = a_vld && (p == a_end);
            if (m_stop) begin
                a_vld = 0; p_vld = 0;
            end else if (ending) begin
                if (p_vld) begin
                    a_pat = p_pat; a_end = p + p_dur * CLKS;
                    p_vld = m_motion; p_pat = mc[4:0]; p_dur = int'(md);
                end else if (m_motion) begin
                    a_pat = mc[4:0]; a_end = p + int'(md) * CLKS;
                end else begin
                    a_vld = 0;
                end
            end else if (m_motion) begin
                if (!a_vld) begin
                    a_vld = 1; a_pat = mc[4:0]; a_end = p + int'(md) * CLKS;
                end else begin
                    e_ovr = p_vld;
                    p_vld = 1; p_pat = mc[4:0]; p_dur = int'(md);
                end
            end
            e_pat  = a_vld ? a_pat : 5'd0;
            e_busy = a_vld;
        end
    end

    // Per-cycle compare and output activity counters.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("cycle_outputs", {23'd0, dut_vec},
                  {23'd0, e_busy, e_ok, e_err, e_ovr, e_pat});
            for (int i = 0; i < 9; i++) hi[i] += int'(dut_vec[i]);
            if (o_err) err_at = pcount;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input int t, input logic [7:0] b);
        while (pcount < t) @(negedge i_clk);
        i_done = 1'b1;
        i_data = b;
        @(negedge i_clk);
        i_done = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        put(pcount, b);
        repeat (idle) @(negedge i_clk);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                         input int gap);
        send(8'hA5, gap);
        send(c, gap);
        send(d, gap);
        send(k, 0);
    endtask

    task automatic take_snap();
        for (int i = 0; i < 9; i++) snap[i] = hi[i];
    endtask

    function automatic int dl(input int i);
        return hi[i] - snap[i];
    endfunction

    initial begin
        int t0, pc;
        logic [7:0] c, d, k;
        int kind, gap, rl, ud, nb;

        for (int i = 0; i < 9; i++) hi[i] = 0;
        i_rst_n = 1'b0; i_done = 1'b0; i_data = 8'h00;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", {23'd0, dut_vec}, 32'd0);
        i_rst_n = 1'b1;
        chk_en  = 1'b1;
        repeat (2) @(negedge i_clk);

        // Run, pending fill, pending overwrite.
        take_snap();
        frame(8'h01, 8'h03, 8'h02, 1);
        check("t1_first_cycle", {23'd0, dut_vec}, 32'b1_1_0_0_00001);
        frame(8'h05, 8'h02, 8'h07, 1);
        frame(8'h12, 8'h01, 8'h13, 0);
        check("t2_ovr_pulse", {31'd0, o_ovr}, 32'd1);
        repeat (60) @(negedge i_clk);
        check("t2_right_cycles", dl(0), 30);
        check("t2_up_never", dl(2), 0);
        check("t2_left_cycles", dl(1), 10);
        check("t2_trig_cycles", dl(4), 10);
        check("t2_busy_cycles", dl(8), 40);
        check("t2_ovr_count", dl(5), 1);
        check("t2_ok_count", dl(7), 3);

        // Rejected frames, then a good one.
        take_snap();
        frame(8'h03, 8'h04, 8'h07, 1);
        check("t3_err_rl", {31'd0, o_err}, 32'd1);
        frame(8'h01, 8'h03, 8'h05, 1);
        check("t3_err_chk", {31'd0, o_err}, 32'd1);
        frame(8'h02, 8'h01, 8'h03, 1);
        repeat (20) @(negedge i_clk);
        check("t3_err_count", dl(6), 2);
        check("t3_left_cycles", dl(1), 10);
        check("t3_right_none", dl(0), 0);

        // Inter-byte timeout.
        take_snap();
        send(8'hA5, 1);
        t0 = pcount;
        put(t0, 8'h01);
        repeat (24) @(negedge i_clk);
        check("t4_err_count", dl(6), 1);
        check("t4_err_cycle", err_at, t0 + 21);
        frame(8'h08, 8'h01, 8'h09, 1);
        repeat (20) @(negedge i_clk);
        check("t4_down_cycles", dl(3), 10);

        // STOP clears active and pending.
        take_snap();
        frame(8'h08, 8'h05, 8'h0D, 1);
        repeat (10) @(negedge i_clk);
        frame(8'h04, 8'h01, 8'h05, 1);
        frame(8'h00, 8'h00, 8'h00, 0);
        check("t5_stop_outputs", {23'd0, dut_vec}, 32'b0_1_0_0_00000);
        repeat (80) @(negedge i_clk);
        check("t5_pending_dropped", dl(2), 0);

        // CHK lands on the last run cycle, pending empty.
        take_snap();
        frame(8'h01, 8'h01, 8'h00, 0);
        pc = pcount;
        put(pc + 3, 8'hA5); put(pc + 5, 8'h02); put(pc + 7, 8'h01); put(pc + 9, 8'h03);
        repeat (30) @(negedge i_clk);
        check("t6a_busy_cycles", dl(8), 20);
        check("t6a_left_cycles", dl(1), 10);
        check("t6a_no_ovr", dl(5), 0);

        // Same coincidence with pending full.
        take_snap();
        frame(8'h01, 8'h01, 8'h00, 0);
        pc = pcount;
        put(pc, 8'hA5);     put(pc + 1, 8'h04); put(pc + 2, 8'h01); put(pc + 3, 8'h05);
        put(pc + 6, 8'hA5); put(pc + 7, 8'h08); put(pc + 8, 8'h02); put(pc + 9, 8'h0A);
        repeat (60) @(negedge i_clk);
        check("t6b_up_cycles", dl(2), 10);
        check("t6b_down_cycles", dl(3), 20);
        check("t6b_busy_cycles", dl(8), 40);
        check("t6b_no_ovr", dl(5), 0);

        // Asynchronous reset mid-run and mid-frame.
        frame(8'h01, 8'h02, 8'h03, 1);
        repeat (5) @(negedge i_clk);
        send(8'hA5, 1);
        send(8'h01, 1);
        check("t7_busy_before_reset", {31'd0, o_busy}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1 check("t7_async_reset", {23'd0, dut_vec}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        take_snap();
        send(8'h01, 1); send(8'hA5, 1); send(8'h02, 1); send(8'h01, 1); send(8'h03, 0);
        check("t7_left_first_cycle", {23'd0, dut_vec}, 32'b1_1_0_0_00010);
        repeat (20) @(negedge i_clk);
        check("t7_left_cycles", dl(1), 10);

        // Random traffic.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(0, 2);
            rl = $urandom_range(0, 2);
            ud = $urandom_range(0, 2);
            c = 8'h00;
            if (rl == 1) c[0] = 1'b1;
            if (rl == 2) c[1] = 1'b1;
            if (ud == 1) c[2] = 1'b1;
            if (ud == 2) c[3] = 1'b1;
            c[4] = 1'($urandom_range(0, 1));
            if (c == 8'h00) c[4] = 1'b1;
            d = 8'($urandom_range(1, 4));
            k = c ^ d;
            case (kind)
                0: begin
                    c = 8'($urandom_range(0, 255));
                    if (c == 8'hA5) c = 8'h5A;
                    send(c, gap);
                end
                1: begin
                    nb = $urandom_range(0, 2);
                    send(8'hA5, gap);
                    for (int j = 0; j < nb; j++) send(8'($urandom_range(0, 255)), gap);
                    repeat ($urandom_range(22, 30)) @(negedge i_clk);
                end
                2: frame(c, d, k ^ 8'h10, gap);
                3: frame(c, 8'h00, c, gap);
                4: begin
                    c = 8'($urandom_range(0, 255));
                    frame(c, d, c ^ d, gap);
                end
                default: frame(c, d, k, gap);
            endcase
            repeat ($urandom_range(0, 25)) @(negedge i_clk);
        end
        repeat (100) @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
